// File: rtl/reg_dst_pipe.sv
// Destination-register select feeding a valid-tagged pipeline (one entry per datapath stage),
// with stall/flush control and read-after-write hazard detection against every in-flight write.
module reg_dst_pipe #(
  parameter int ADDR_W          = 5,
  parameter int NUM_SRC         = 3,
  parameter int SEL_W           = 2,
  parameter int STAGES          = 3,
  parameter int ZERO_REG_IGNORE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         chk_a,
  input  logic [ADDR_W-1:0]         chk_b,
  output logic [ADDR_W-1:0]         dest_out,
  output logic                      dest_valid,
  output logic                      hazard_a,
  output logic                      hazard_b,
  output logic                      sel_err
);

  logic [ADDR_W-1:0] addr_q [STAGES];
  logic [ADDR_W-1:0] addr_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic              sel_err_q, sel_err_d;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_ok;

  // Decoding sel against each legal index gives the out-of-range flag for free
  // and never slices beyond the packed candidate vector.
  always_comb begin
    sel_addr = '0;
    sel_ok   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok   = 1'b1;
        sel_addr = src_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    addr_d    = addr_q;
    valid_d   = valid_q;
    sel_err_d = 1'b0;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d[0] = in_valid && sel_ok;
      addr_d[0]  = (in_valid && sel_ok) ? sel_addr : '0;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k]  = addr_q[k-1];
      end
      sel_err_d = in_valid && !sel_ok;
    end
  end

  // NOTE: the stage array is reset entry by entry; its contents drive outputs
  // and hazard compares directly, so no entry may come up as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        addr_q[k] <= '0;
      end
      valid_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge
      // value of its predecessor, independent of statement order.
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Hazards look only at registered state; $zero is never a real dependency.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (valid_q[k] && (addr_q[k] == chk_a)) hazard_a = 1'b1;
      if (valid_q[k] && (addr_q[k] == chk_b)) hazard_b = 1'b1;
    end
    if ((ZERO_REG_IGNORE != 0) && (chk_a == '0)) hazard_a = 1'b0;
    if ((ZERO_REG_IGNORE != 0) && (chk_b == '0)) hazard_b = 1'b0;
  end

  assign dest_out   = addr_q[STAGES-1];
  assign dest_valid = valid_q[STAGES-1];
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_reg_dst_pipe.sv
// Directed bench for reg_dst_pipe (NUM_SRC=3, STAGES=3): a vector table plus
// hand-written reset sequences.
module tb_reg_dst_pipe;

  localparam logic [14:0] S0 = {5'd31, 5'd12, 5'd7};
  localparam logic [14:0] SZ = {5'd31, 5'd12, 5'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  sel;
  logic [14:0] src_addr;
  logic        stall, flush;
  logic [4:0]  chk_a, chk_b;
  logic [4:0]  dest_out;
  logic        dest_valid, hazard_a, hazard_b, sel_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [14:0] src;
    logic        iv;
    logic [1:0]  sl;
    logic        st;
    logic        fl;
    logic [4:0]  ca;
    logic [4:0]  cb;
    logic [4:0]  dest;
    logic        dest_chk;
    logic        dv;
    logic        ha;
    logic        hb;
    logic        se;
  } vec_t;

  vec_t vecs[$];

  reg_dst_pipe #(
    .ADDR_W(5), .NUM_SRC(3), .SEL_W(2), .STAGES(3), .ZERO_REG_IGNORE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel), .src_addr(src_addr),
    .stall(stall), .flush(flush), .chk_a(chk_a), .chk_b(chk_b),
    .dest_out(dest_out), .dest_valid(dest_valid), .hazard_a(hazard_a),
    .hazard_b(hazard_b), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [14:0] s, input logic iv, input logic [1:0] sl,
                     input logic st, input logic fl, input logic [4:0] ca, input logic [4:0] cb,
                     input logic [4:0] d, input logic dchk, input logic dv,
                     input logic ha, input logic hb, input logic se);
    vec_t v;
    v.src = s; v.iv = iv; v.sl = sl; v.st = st; v.fl = fl; v.ca = ca; v.cb = cb;
    v.dest = d; v.dest_chk = dchk; v.dv = dv; v.ha = ha; v.hb = hb; v.se = se;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [14:0] s, input logic iv, input logic [1:0] sl,
                      input logic st, input logic fl);
    src_addr = s; in_valid = iv; sel = sl; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dest_out"},   32'(dest_out),   32'd0);
    check({tag, " dest_valid"}, 32'(dest_valid), 32'd0);
    check({tag, " hazard_a"},   32'(hazard_a),   32'd0);
    check({tag, " hazard_b"},   32'(hazard_b),   32'd0);
    check({tag, " sel_err"},    32'(sel_err),    32'd0);
  endtask

  initial begin
    // Single write of reg 12 travels the pipe
    //   src iv sl st fl ca  cb  dest dchk dv ha hb se
    add(S0, 1, 1, 0, 0, 12,  7,  0, 1, 0, 1, 0, 0);
    add(S0, 0, 0, 0, 0, 12,  7,  0, 1, 0, 1, 0, 0);
    add(S0, 0, 0, 0, 0, 12,  7, 12, 1, 1, 1, 0, 0);
    add(S0, 0, 0, 0, 0, 12,  7,  0, 1, 0, 0, 0, 0);
    // Back-to-back sel 0,1,2 -> 7,12,31
    add(S0, 1, 0, 0, 0, 31,  7,  0, 1, 0, 0, 1, 0);
    add(S0, 1, 1, 0, 0, 31,  7,  0, 1, 0, 0, 1, 0);
    add(S0, 1, 2, 0, 0, 31,  7,  7, 1, 1, 1, 1, 0);
    add(S0, 0, 0, 0, 0, 31,  7, 12, 1, 1, 1, 0, 0);
    add(S0, 0, 0, 0, 0, 31,  7, 31, 1, 1, 1, 0, 0);
    add(S0, 0, 0, 0, 0, 31,  7,  0, 1, 0, 0, 0, 0);
    // Stalls mid-stream, with live inputs ignored
    add(S0, 1, 0, 0, 0,  7, 12,  0, 1, 0, 1, 0, 0);
    add(S0, 1, 1, 0, 0,  7, 12,  0, 1, 0, 1, 1, 0);
    add(S0, 1, 2, 1, 0,  7, 12,  0, 1, 0, 1, 1, 0);
    add(S0, 1, 2, 1, 0,  7, 12,  0, 1, 0, 1, 1, 0);
    add(S0, 1, 2, 0, 0,  7, 12,  7, 1, 1, 1, 1, 0);
    add(S0, 1, 0, 1, 0,  7, 12,  7, 1, 1, 1, 1, 0);
    add(S0, 0, 0, 0, 0,  7, 12, 12, 1, 1, 0, 1, 0);
    add(S0, 0, 0, 0, 0,  7, 12, 31, 1, 1, 0, 0, 0);
    add(S0, 0, 0, 0, 0,  7, 12,  0, 1, 0, 0, 0, 0);
    // Flush beats stall and a presented write; held addresses are don't-care
    add(S0, 1, 1, 0, 0, 12, 31,  0, 1, 0, 1, 0, 0);
    add(S0, 1, 2, 0, 0, 12, 31,  0, 1, 0, 1, 1, 0);
    add(S0, 1, 0, 1, 1, 12, 31,  0, 1, 0, 0, 0, 0);
    add(S0, 0, 0, 0, 0, 12, 31,  0, 0, 0, 0, 0, 0);
    add(S0, 0, 0, 0, 0, 12,  7,  0, 0, 0, 0, 0, 0);
    add(S0, 0, 0, 0, 0, 12,  7,  0, 1, 0, 0, 0, 0);
    // Out-of-range sel
    add(S0, 1, 3, 0, 0,  7, 12,  0, 1, 0, 0, 0, 1);
    add(S0, 0, 3, 0, 0,  7, 12,  0, 1, 0, 0, 0, 0);
    add(S0, 0, 0, 0, 0,  7, 12,  0, 1, 0, 0, 0, 0);
    add(S0, 1, 3, 1, 0,  7, 12,  0, 1, 0, 0, 0, 0);
    add(S0, 1, 3, 0, 1,  7, 12,  0, 1, 0, 0, 0, 0);
    // Write to $zero: valid but never a hazard
    add(SZ, 1, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0, 0);
    add(SZ, 0, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0, 0);
    add(SZ, 0, 0, 0, 0,  0,  0,  0, 1, 1, 0, 0, 0);
    add(SZ, 0, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0, 0);

    rst_n = 1'b0; in_valid = 1'b0; sel = '0; src_addr = S0;
    stall = 1'b0; flush = 1'b0; chk_a = 5'd12; chk_b = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      chk_a = vecs[i].ca;
      chk_b = vecs[i].cb;
      step(vecs[i].src, vecs[i].iv, vecs[i].sl, vecs[i].st, vecs[i].fl);
      if (vecs[i].dest_chk) check({tag, " dest_out"}, 32'(dest_out), 32'(vecs[i].dest));
      check({tag, " dest_valid"}, 32'(dest_valid), 32'(vecs[i].dv));
      check({tag, " hazard_a"},   32'(hazard_a),   32'(vecs[i].ha));
      check({tag, " hazard_b"},   32'(hazard_b),   32'(vecs[i].hb));
      check({tag, " sel_err"},    32'(sel_err),    32'(vecs[i].se));
    end

    // Asynchronous reset mid-stream clears outputs without a clock edge
    chk_a = 5'd12; chk_b = 5'd31;
    step(S0, 1, 0, 0, 0);
    step(S0, 1, 1, 0, 0);
    step(S0, 1, 2, 0, 0);
    check("midrst pre dest_out", 32'(dest_out), 32'd7);
    check("midrst pre hazard_a", 32'(hazard_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // First accept lands on the first edge after release
    step(S0, 1, 1, 0, 0);
    check("post-rst hazard_a", 32'(hazard_a), 32'd1);
    step(S0, 0, 0, 0, 0);
    step(S0, 0, 0, 0, 0);
    check("post-rst dest_out",   32'(dest_out),   32'd12);
    check("post-rst dest_valid", 32'(dest_valid), 32'd1);

    // A pending sel_err pulse is also cleared by reset
    step(S0, 1, 3, 0, 0);
    check("serr pulse", 32'(sel_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("serr reset", 32'(sel_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(S0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
